// File: rtl/image_pkg.sv
// Shared types and helpers for the image capture packer: FSM states,
// the Avalon-ST beat record and byte-placement helpers.
package image_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        TRUNC,
        DROP
    } pack_state_t;

    localparam int PIX_PER_WORD = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  empty;
        logic        sop;
        logic        eop;
    } beat_t;

    // Place a pixel at byte slot idx, slot 0 being bits [31:24].
    function automatic logic [31:0] put_pixel(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  pix);
        logic [31:0] w;
        w = word;
        w[8 * (3 - int'(idx)) +: 8] = pix;
        return w;
    endfunction

    // Unused trailing bytes for a word holding n_pix (1..4) pixels.
    function automatic logic [1:0] empty_for(input logic [2:0] n_pix);
        logic [2:0] e;
        e = 3'(PIX_PER_WORD) - n_pix;
        return e[1:0];
    endfunction

endpackage

// File: rtl/image_st_out_queue.sv
// Small output queue of beats. Implemented as a shift register so the head
// entry is always a flop; a pop and a push in the same cycle both succeed,
// even when the queue is full.
module image_st_out_queue
    import image_pkg::*;
#(
    parameter  int DEPTH  = 4,
    localparam int QCNT_W = $clog2(DEPTH + 1)
) (
    input  logic              wrclk,
    input  logic              wrreset_n,
    input  logic              push_valid,
    input  beat_t             push_beat,
    output beat_t             head_beat,
    input  logic              head_ready,
    output logic              full,
    output logic              empty,
    output logic [QCNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    beat_t             slot_q [DEPTH];
    logic [QCNT_W-1:0] count_q;
    logic              pop;
    logic              push_ok;
    logic [AW-1:0]     wr_idx;

    assign empty     = (count_q == '0);
    assign full      = (count_q == QCNT_W'(DEPTH));
    assign count     = count_q;
    assign head_beat = slot_q[0];

    assign pop     = !empty & head_ready;
    assign push_ok = push_valid & (!full | pop);
    // When popping, everything shifts down one slot, so the write lands one lower.
    assign wr_idx  = AW'(pop ? count_q - QCNT_W'(1) : count_q);

    // Shift on pop, write the new beat behind the last occupied slot, track occupancy.
    always_ff @(posedge wrclk or negedge wrreset_n) begin
        if (!wrreset_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) slot_q[i] <= slot_q[i + 1];
                slot_q[DEPTH - 1] <= '0;
            end
            if (push_ok) slot_q[wr_idx] <= push_beat;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + QCNT_W'(1);
                2'b01:   count_q <= count_q - QCNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/image_pixel_packer.sv
// Packs the camera 8-bit pixel stream into 32-bit Avalon-ST packets
// (first pixel in [31:24]). The camera cannot stall, so when the output
// queue is full the current frame is cut short with a well-formed eop beat.
module image_pixel_packer
    import image_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_W       = 16
) (
    input  logic             wrclk,
    input  logic             wrreset_n,
    input  logic             enable,
    input  logic [7:0]       pix_data,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic             pix_eof,
    output logic [31:0]      src_data,
    output logic [1:0]       src_empty,
    output logic             src_sop,
    output logic             src_eop,
    output logic             src_valid,
    input  logic             src_ready,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow,
    output logic             frame_err
);

    localparam int QCNT_W = $clog2(QUEUE_DEPTH + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pack_state_t       state_q, state_d;
    logic [31:0]       word_q, word_d, word_ins;
    logic [2:0]        cnt_q, cnt_d;
    logic              sop_pend_q, sop_pend_d;
    logic              eof_seen_q, eof_seen_d;
    logic              push, drop_evt, err_evt;
    beat_t             push_beat, head_beat;
    logic              q_full, q_empty;
    logic [QCNT_W-1:0] q_count;
    logic              unused_q_count;
    logic              space, start, full_word, need_push;

    assign src_valid = !q_empty;
    assign src_data  = head_beat.data;
    assign src_empty = head_beat.empty;
    assign src_sop   = head_beat.sop;
    assign src_eop   = head_beat.eop;
    // Queue occupancy is not needed by the packer itself.
    assign unused_q_count = ^q_count;

    // A slot frees up in the same cycle if the head is being taken.
    assign space     = !q_full | (src_valid & src_ready);
    assign start     = pix_valid & pix_sof & enable;
    assign full_word = (cnt_q == 3'(PIX_PER_WORD));
    assign word_ins  = put_pixel(word_q, cnt_q[1:0], pix_data);
    assign need_push = pix_valid & (pix_sof | pix_eof | full_word);

    // FSM state register.
    always_ff @(posedge wrclk or negedge wrreset_n) begin
        if (!wrreset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next-state decode. TRUNC also serves as a one-beat flush when a frame
    // ends with two words due in one cycle (held word plus eof/sof pixel).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DROP: begin
                if (start) state_d = !pix_eof ? PACK : (space ? IDLE : TRUNC);
            end
            PACK: begin
                if (need_push) begin
                    if (!space)                              state_d = TRUNC;
                    else if (pix_eof && (pix_sof || full_word)) state_d = TRUNC;
                    else if (pix_eof)                        state_d = IDLE;
                end
            end
            TRUNC: begin
                if (space) state_d = (eof_seen_q || (pix_valid && pix_eof)) ? IDLE : DROP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: queue push, next pending word and statistics events.
    always_comb begin
        push       = 1'b0;
        push_beat  = '0;
        word_d     = word_q;
        cnt_d      = cnt_q;
        sop_pend_d = sop_pend_q;
        eof_seen_d = eof_seen_q;
        drop_evt   = 1'b0;
        err_evt    = 1'b0;
        case (state_q)
            IDLE, DROP: begin
                if (start) begin
                    word_d     = {pix_data, 24'h0};
                    cnt_d      = 3'd1;
                    sop_pend_d = 1'b1;
                    eof_seen_d = pix_eof;
                    if (pix_eof) begin
                        push_beat = '{data: {pix_data, 24'h0}, empty: 2'd3, sop: 1'b1, eop: 1'b1};
                        if (space) begin
                            push       = 1'b1;
                            cnt_d      = 3'd0;
                            sop_pend_d = 1'b0;
                            eof_seen_d = 1'b0;
                        end else begin
                            drop_evt = 1'b1;
                        end
                    end
                end
            end
            PACK: begin
                if (pix_valid) begin
                    if (pix_sof || full_word) begin
                        // Current word leaves first; a mid-frame sof closes the old frame.
                        push_beat = '{data: word_q, empty: empty_for(cnt_q), sop: sop_pend_q, eop: pix_sof};
                        err_evt   = pix_sof;
                        if (space) begin
                            push       = 1'b1;
                            word_d     = {pix_data, 24'h0};
                            cnt_d      = 3'd1;
                            sop_pend_d = pix_sof;
                            eof_seen_d = pix_eof;
                        end else begin
                            drop_evt   = 1'b1;
                            eof_seen_d = pix_eof & !pix_sof;
                        end
                    end else if (pix_eof) begin
                        push_beat = '{data: word_ins, empty: empty_for(cnt_q + 3'd1), sop: sop_pend_q, eop: 1'b1};
                        if (space) begin
                            push       = 1'b1;
                            word_d     = '0;
                            cnt_d      = 3'd0;
                            sop_pend_d = 1'b0;
                        end else begin
                            drop_evt   = 1'b1;
                            word_d     = word_ins;
                            cnt_d      = cnt_q + 3'd1;
                            eof_seen_d = 1'b1;
                        end
                    end else begin
                        word_d = word_ins;
                        cnt_d  = cnt_q + 3'd1;
                    end
                end
            end
            TRUNC: begin
                push_beat = '{data: word_q, empty: empty_for(cnt_q), sop: sop_pend_q, eop: 1'b1};
                if (space) begin
                    push       = 1'b1;
                    word_d     = '0;
                    cnt_d      = 3'd0;
                    sop_pend_d = 1'b0;
                    eof_seen_d = 1'b0;
                end else if (pix_valid && pix_eof) begin
                    eof_seen_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pending word, fill level and frame flags.
    always_ff @(posedge wrclk or negedge wrreset_n) begin
        if (!wrreset_n) begin
            word_q     <= '0;
            cnt_q      <= '0;
            sop_pend_q <= 1'b0;
            eof_seen_q <= 1'b0;
        end else begin
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            sop_pend_q <= sop_pend_d;
            eof_seen_q <= eof_seen_d;
        end
    end

    // Saturating statistics and sticky flags; clear wins over any update.
    always_ff @(posedge wrclk or negedge wrreset_n) begin
        if (!wrreset_n) begin
            frame_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
            frame_err   <= 1'b0;
        end else if (clr_stats) begin
            frame_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (push && push_beat.eop) frame_count <= sat_inc(frame_count);
            if (drop_evt)              drop_count  <= sat_inc(drop_count);
            overflow  <= overflow | drop_evt;
            frame_err <= frame_err | err_evt;
        end
    end

    image_st_out_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .wrclk      (wrclk),
        .wrreset_n  (wrreset_n),
        .push_valid (push),
        .push_beat  (push_beat),
        .head_beat  (head_beat),
        .head_ready (src_ready),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count)
    );

endmodule

// File: tb/tb_image_pixel_packer.sv
// Directed bench for image_pixel_packer: drives pixel frames, collects the
// accepted Avalon-ST beats and compares them with hand-computed words.
module tb_image_pixel_packer;

    logic        wrclk = 1'b0;
    logic        wrreset_n;
    logic        enable;
    logic [7:0]  pix_data;
    logic        pix_valid, pix_sof, pix_eof;
    logic [31:0] src_data;
    logic [1:0]  src_empty;
    logic        src_sop, src_eop, src_valid, src_ready;
    logic        clr_stats;
    logic [15:0] frame_count, drop_count;
    logic        overflow, frame_err;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  e;
        logic        s;
        logic        p;
    } cap_t;

    cap_t cap_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 wrclk = ~wrclk;

    image_pixel_packer #(
        .QUEUE_DEPTH (4),
        .CNT_W       (16)
    ) dut (
        .wrclk       (wrclk),
        .wrreset_n   (wrreset_n),
        .enable      (enable),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_sof     (pix_sof),
        .pix_eof     (pix_eof),
        .src_data    (src_data),
        .src_empty   (src_empty),
        .src_sop     (src_sop),
        .src_eop     (src_eop),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .clr_stats   (clr_stats),
        .frame_count (frame_count),
        .drop_count  (drop_count),
        .overflow    (overflow),
        .frame_err   (frame_err)
    );

    // Record every beat that transfers at the coming rising edge.
    always @(negedge wrclk) begin
        if (wrreset_n && src_valid && src_ready)
            cap_q.push_back('{d: src_data, e: src_empty, s: src_sop, p: src_eop});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic pix(input logic [7:0] d, input bit sof, input bit eof);
        @(posedge wrclk);
        #1;
        pix_data  = d;
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_eof   = eof;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge wrclk);
            #1;
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
            pix_eof   = 1'b0;
            pix_data  = 8'h00;
            clr_stats = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) pix(first + 8'(i), i == 0, i == n - 1);
    endtask

    task automatic check_beat(input string tag, input logic [31:0] d, input logic [1:0] e,
                              input logic s, input logic p);
        cap_t b;
        int   waited = 0;
        while (cap_q.size() == 0 && waited < 20) begin
            @(posedge wrclk);
            waited++;
        end
        chk({tag, "_present"}, 32'(cap_q.size() != 0), 32'd1);
        if (cap_q.size() != 0) begin
            b = cap_q.pop_front();
            chk({tag, "_data"}, b.d, d);
            chk({tag, "_empty_sop_eop"}, {28'h0, b.e, b.s, b.p}, {28'h0, e, s, p});
        end
    endtask

    initial begin
        wrreset_n = 1'b0;
        enable    = 1'b1;
        pix_data  = 8'h00;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_eof   = 1'b0;
        src_ready = 1'b1;
        clr_stats = 1'b0;
        repeat (3) @(posedge wrclk);
        #1;
        chk("rst_valid", 32'(src_valid), 32'd0);
        chk("rst_data", src_data, 32'h0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        chk("rst_flags", {30'h0, overflow, frame_err}, 32'd0);
        wrreset_n = 1'b1;
        idle(2);

        // 8-pixel frame, eop beat one cycle after the eof pixel
        send_frame(8'h01, 8);
        idle(1);
        chk("t1_lat_valid", 32'(src_valid), 32'd1);
        chk("t1_lat_eop", 32'(src_eop), 32'd1);
        check_beat("t1_b0", 32'h01020304, 2'd0, 1'b1, 1'b0);
        check_beat("t1_b1", 32'h05060708, 2'd0, 1'b0, 1'b1);
        idle(2);
        chk("t1_frame_count", 32'(frame_count), 32'd1);

        // 6-pixel frame: short last word
        send_frame(8'h01, 6);
        idle(3);
        check_beat("t2_b0", 32'h01020304, 2'd0, 1'b1, 1'b0);
        check_beat("t2_b1", 32'h05060000, 2'd2, 1'b0, 1'b1);
        chk("t2_frame_count", 32'(frame_count), 32'd2);

        // single pixel with sof and eof
        pix(8'hAA, 1'b1, 1'b1);
        idle(3);
        check_beat("t3_b0", 32'hAA000000, 2'd3, 1'b1, 1'b1);
        chk("t3_frame_count", 32'(frame_count), 32'd3);

        // sof arriving after 5 pixels closes the frame early
        for (int i = 1; i <= 5; i++) pix(8'(i), i == 1, 1'b0);
        pix(8'h21, 1'b1, 1'b0);
        pix(8'h22, 1'b0, 1'b0);
        pix(8'h23, 1'b0, 1'b1);
        idle(3);
        check_beat("t4_b0", 32'h01020304, 2'd0, 1'b1, 1'b0);
        check_beat("t4_b1", 32'h05000000, 2'd3, 1'b0, 1'b1);
        check_beat("t4_b2", 32'h21222300, 2'd1, 1'b1, 1'b1);
        chk("t4_frame_err", 32'(frame_err), 32'd1);
        chk("t4_frame_count", 32'(frame_count), 32'd5);
        chk("t4_drain", 32'(cap_q.size()), 32'd0);

        // clear statistics
        @(posedge wrclk);
        #1;
        clr_stats = 1'b1;
        idle(1);
        chk("clr_frame_count", 32'(frame_count), 32'd0);
        chk("clr_frame_err", 32'(frame_err), 32'd0);

        // 40-pixel frame with the sink stalled: truncation at pixel 21
        src_ready = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            pix(8'(i), i == 1, i == 40);
            if (i == 21) chk("t5_no_ovf_at20", 32'(overflow), 32'd0);
            if (i == 22) chk("t5_ovf_at21", 32'(overflow), 32'd1);
        end
        idle(2);
        chk("t5_hold_data", src_data, 32'h01020304);
        chk("t5_hold_sop", 32'(src_sop), 32'd1);
        chk("t5_drop_count", 32'(drop_count), 32'd1);
        src_ready = 1'b1;
        idle(8);
        check_beat("t5_b0", 32'h01020304, 2'd0, 1'b1, 1'b0);
        check_beat("t5_b1", 32'h05060708, 2'd0, 1'b0, 1'b0);
        check_beat("t5_b2", 32'h090A0B0C, 2'd0, 1'b0, 1'b0);
        check_beat("t5_b3", 32'h0D0E0F10, 2'd0, 1'b0, 1'b0);
        check_beat("t5_b4", 32'h11121314, 2'd0, 1'b0, 1'b1);
        chk("t5_drain", 32'(cap_q.size()), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd1);
        chk("t5_frame_count", 32'(frame_count), 32'd1);
        send_frame(8'h31, 4);
        idle(3);
        check_beat("t5_next", 32'h31323334, 2'd0, 1'b1, 1'b1);
        chk("t5_frame_count2", 32'(frame_count), 32'd2);

        // asynchronous reset mid-frame with a beat queued
        src_ready = 1'b0;
        for (int i = 0; i < 6; i++) pix(8'h41 + 8'(i), i == 0, 1'b0);
        idle(2);
        chk("t6_valid_pre", 32'(src_valid), 32'd1);
        #3;
        wrreset_n = 1'b0;
        #1;
        chk("t6_valid_rst", 32'(src_valid), 32'd0);
        chk("t6_frame_count", 32'(frame_count), 32'd0);
        chk("t6_drop_count", 32'(drop_count), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge wrclk);
        #1;
        wrreset_n = 1'b1;
        src_ready = 1'b1;
        idle(1);
        send_frame(8'h51, 8);
        idle(3);
        check_beat("t6_b0", 32'h51525354, 2'd0, 1'b1, 1'b0);
        check_beat("t6_b1", 32'h55565758, 2'd0, 1'b0, 1'b1);
        chk("t6_drain", 32'(cap_q.size()), 32'd0);
        chk("t6_frame_count_after", 32'(frame_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
